credential_entry_ctrl: RTL

//  Front-end sequencer for the login/user-management unlocker. Collects keypad digits into
//  the 4x4-bit user-name and password fields and drives the entry count the unlocker consumes.

---
 rtl/credential_entry_pkg.sv | 15 +
 rtl/credential_entry_if.sv | 35 +++
 rtl/credential_entry_lockout_timer.sv | 53 +++++
 rtl/credential_entry_ctrl.sv | 120 ++++++++++++
 4 files changed

// File: rtl/credential_entry_pkg.sv
// Shared constants and state encoding for the credential entry sequencer.
package credential_entry_pkg;

   localparam int NIBBLE_W    = 4;
   localparam int NAME_DIGITS = 4;
   localparam logic [3:0] ENTRY_FULL = 4'd8;

   localparam logic [1:0] ST_ENTRY    = 2'd0;
   localparam logic [1:0] ST_FLAG_ACK = 2'd1;
   localparam logic [1:0] ST_LOCKOUT  = 2'd2;
   localparam logic [1:0] ST_RESOLVE  = 2'd3;

   typedef logic [NIBBLE_W-1:0] nibble_t;

endpackage

// File: rtl/credential_entry_if.sv
// Keypad/unlocker signal bundle between the credential entry sequencer and its environment.
interface credential_entry_if;
   import credential_entry_pkg::*;

   logic       digit_valid;
   nibble_t    digit;
   logic       backspace;
   logic       clear;
   logic       ack_btn;
   logic       reset_count;
   logic       flag;
   logic       flag_select;

   logic [3:0] input_count;
   nibble_t    user_name0, user_name1, user_name2, user_name3;
   nibble_t    password0, password1, password2, password3;
   logic       flag_resolve;
   logic       lockout_active;
   logic [7:0] lockout_remaining;

   modport master (
      output digit_valid, digit, backspace, clear, ack_btn, reset_count, flag, flag_select,
      input  input_count, user_name0, user_name1, user_name2, user_name3,
             password0, password1, password2, password3,
             flag_resolve, lockout_active, lockout_remaining
   );

   modport slave (
      input  digit_valid, digit, backspace, clear, ack_btn, reset_count, flag, flag_select,
      output input_count, user_name0, user_name1, user_name2, user_name3,
             password0, password1, password2, password3,
             flag_resolve, lockout_active, lockout_remaining
   );

endinterface

// File: rtl/credential_entry_lockout_timer.sv
// Lockout timer: tick divider plus tick down-counter; idles at zero when neither loaded nor running.
module lockout_timer #(
   parameter int unsigned TICK_DIV      = 100_000_000,
   parameter int unsigned LOCKOUT_TICKS = 30
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       run,
   output logic       done,
   output logic [7:0] remaining
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_MAX   = TW'(TICK_DIV - 1);
   localparam logic [7:0]    TICKS_INIT = 8'(LOCKOUT_TICKS);

   logic [TW-1:0] tick_q, tick_d;
   logic [7:0]    rem_q, rem_d;
   logic          tick_wrap;

   assign tick_wrap = (tick_q == '0);
   assign done      = run && tick_wrap && (rem_q == 8'd1);
   assign remaining = rem_q;

   always_comb begin
      tick_d = '0;
      rem_d  = '0;
      if (load) begin
         tick_d = TICK_MAX;
         rem_d  = TICKS_INIT;
      end else if (run) begin
         if (tick_wrap) begin
            tick_d = TICK_MAX;
            rem_d  = (rem_q != 8'd0) ? rem_q - 8'd1 : 8'd0;
         end else begin
            tick_d = tick_q - TW'(1);
            rem_d  = rem_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_q <= '0;
         rem_q  <= '0;
      end else begin
         tick_q <= tick_d;
         rem_q  <= rem_d;
      end
   end

endmodule

// File: rtl/credential_entry_ctrl.sv
// Credential entry sequencer: keypad entry buffer plus flag acknowledge / lockout FSM.
//  state     | meaning
//  ENTRY     | keypad active, watching the unlocker flag
//  FLAG_ACK  | single wrong attempt, waiting for operator ack_btn
//  LOCKOUT   | third wrong attempt, timed lockout running
//  RESOLVE   | flag_resolve high until the unlocker drops flag
module credential_entry_ctrl
   import credential_entry_pkg::*;
#(
   parameter int unsigned TICK_DIV      = 100_000_000,
   parameter int unsigned LOCKOUT_TICKS = 30
) (
   input logic               clk,
   input logic               rst_n,
   credential_entry_if.slave bus
);

   logic [1:0] state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [ENTRY_FULL-1:0][NIBBLE_W-1:0] slots_q, slots_d;
   logic rc_last_q, rc_last_d;

   logic       rc_rise;
   logic       entry_clr;
   logic [2:0] bs_idx;
   logic       tmr_load, tmr_run, tmr_done;
   logic [7:0] tmr_remaining;

   assign rc_rise  = bus.reset_count && !rc_last_q;
   assign bs_idx   = cnt_q[2:0] - 3'd1;
   assign tmr_load = (state_q == ST_ENTRY) && bus.flag && bus.flag_select;
   // timer clears itself the same edge flag drops, so remaining reads 0 back in ENTRY
   assign tmr_run  = (state_q == ST_LOCKOUT) && bus.flag;

   lockout_timer #(
      .TICK_DIV      (TICK_DIV),
      .LOCKOUT_TICKS (LOCKOUT_TICKS)
   ) u_lockout_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (tmr_load),
      .run       (tmr_run),
      .done      (tmr_done),
      .remaining (tmr_remaining)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      slots_d   = slots_q;
      rc_last_d = bus.reset_count;
      entry_clr = 1'b0;
      case (state_q)
         ST_ENTRY: begin
            if (bus.flag) begin
               entry_clr = 1'b1;
               state_d   = bus.flag_select ? ST_LOCKOUT : ST_FLAG_ACK;
            end else if (rc_rise || bus.clear) begin
               entry_clr = 1'b1;
            end else if (bus.backspace && (cnt_q != 4'd0)) begin
               cnt_d           = cnt_q - 4'd1;
               slots_d[bs_idx] = '0;
            end else if (bus.digit_valid && (cnt_q < ENTRY_FULL)) begin
               cnt_d               = cnt_q + 4'd1;
               slots_d[cnt_q[2:0]] = bus.digit;
            end
         end
         ST_FLAG_ACK: begin
            if (!bus.flag)        state_d = ST_ENTRY;
            else if (bus.ack_btn) state_d = ST_RESOLVE;
         end
         ST_LOCKOUT: begin
            if (!bus.flag)     state_d = ST_ENTRY;
            else if (tmr_done) state_d = ST_RESOLVE;
         end
         ST_RESOLVE: begin
            if (!bus.flag) begin
               state_d   = ST_ENTRY;
               entry_clr = 1'b1;
            end
         end
         default: state_d = ST_ENTRY;
      endcase
      if (rc_rise) entry_clr = 1'b1;
      if (entry_clr) begin
         cnt_d   = 4'd0;
         slots_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_ENTRY;
         cnt_q     <= 4'd0;
         slots_q   <= '0;
         rc_last_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         slots_q   <= slots_d;
         rc_last_q <= rc_last_d;
      end
   end

   // first key lands in the most significant user-name nibble
   assign bus.user_name3 = slots_q[0];
   assign bus.user_name2 = slots_q[1];
   assign bus.user_name1 = slots_q[2];
   assign bus.user_name0 = slots_q[3];
   assign bus.password3  = slots_q[NAME_DIGITS + 0];
   assign bus.password2  = slots_q[NAME_DIGITS + 1];
   assign bus.password1  = slots_q[NAME_DIGITS + 2];
   assign bus.password0  = slots_q[NAME_DIGITS + 3];

   assign bus.input_count       = cnt_q;
   assign bus.flag_resolve      = (state_q == ST_RESOLVE);
   assign bus.lockout_active    = (state_q == ST_LOCKOUT);
   assign bus.lockout_remaining = tmr_remaining;

endmodule
